z80_snd_bus_ctrl: RTL and testbench
===================================

// Module: z80_snd_bus_ctrl
// PURPOSE
//  Bus controller for the sound Z80. It decodes the CPU strobes and address into chip selects.
//  It sequences ROM fetches through an external req/ack memory port, holding WAIT_n low until data arrives.
//  It muxes read data back to the CPU and owns the 68k->Z80 sound latch and the Z80 INT_n generation.
//  It sits between the cpu_z80 wrapper and the sound ROM/RAM, YM2151 and K007232.
// PARAMETERS
//  ROM_TOP   16'h7FFF  last ROM address; ROM spans 0000..ROM_TOP
//  RAM_BASE  16'h8000  RAM base; RAM spans 2 KiB (A[10:0])
//  LAT_BASE  16'hA000  sound latch read address (exact match)
//  YM_BASE   16'hC000  YM2151 window (A[15:1] match, A0 = reg/data)
//  K7_BASE   16'hB000  K007232 window (A[15:4] match)
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  reset      in   1   synchronous, active-high
//  z_addr     in   16  Z80 address
//  z_dout     in   8   Z80 write data
//  z_nmreq/z_niorq/z_nrd/z_nwr/z_nrfsh  in 1 each  Z80 strobes, active low
//  z_din      out  8   read data to Z80
//  z_nwait    out  1   WAIT_n to Z80
//  z_nint     out  1   INT_n to Z80
//  rom_req    out  1   ROM fetch request (level)
//  rom_addr   out  15  latched ROM address
//  rom_ack    in   1   1-cycle pulse: rom_data valid
//  rom_data   in   8   ROM data
//  ram_cs/ram_we  out 1  RAM select / write enable
//  ram_q      in   8   RAM read data (1-cycle sync)
//  ym_cs/ym_we    out 1  YM2151 select / write
//  ym_q       in   8   YM2151 status
//  k7_cs/k7_we    out 1  K007232 select / write
//  k7_q       in   8   K007232 read data
//  lat_wr     in   1   1-cycle strobe from 68k side (same clk): load latch
//  lat_data   in   8   latch data from 68k
// BEHAVIOUR
//  Reset values: z_nwait=1, z_nint=1, rom_req=0, rom_addr=0, all cs/we=0, z_din=8'hFF, latch=0, irq_pend=0.
//  Memory cycle: MEMRD = ~z_nmreq & z_nrfsh & ~z_nrd; MEMWR = ~z_nmreq & z_nrfsh & ~z_nwr.
//    Refresh cycles (z_nrfsh=0) never select anything.
//  Chip selects are registered: they are valid 1 cycle after the strobe and drop the cycle after the strobe deasserts.
//  Writes to ROM space are ignored. Unmapped reads return 8'hFF. IORQ cycles are unmapped and return FF.
//  ROM FSM:
//    IDLE -> on MEMRD rising with addr<=ROM_TOP: rom_addr<=A[14:0], rom_req<=1, z_nwait<=0 => REQ.
//    REQ  -> on rom_ack: latch rom_data, rom_req<=0, z_nwait<=1 => HOLD.
//    HOLD -> on z_nrd=1 => IDLE.
//    z_nwait goes low in the same cycle rom_req rises. Minimum stall is 1 cycle after ack.
//    rom_ack while in IDLE/HOLD is ignored.
//  Read mux: z_din is registered from the selected source (ROM latch / ram_q / ym_q / k7_q / latch), else FF.
//    z_din is held for the duration of the read strobe.
//  Latch: lat_wr loads latch and sets irq_pend. z_nint = ~irq_pend (registered).
//    A Z80 MEMRD of LAT_BASE clears irq_pend on the strobe rising edge, one clear per read cycle.
//    If lat_wr and the clearing read occur in the same cycle, lat_wr wins: pend stays 1 and the read returns the old latch value.
//  Reset mid-fetch: FSM returns to IDLE next edge, rom_req=0, z_nwait=1. A late rom_ack is ignored.
// STRUCTURE
//  Shared package snd_bus_pkg: region enum {R_NONE,R_ROM,R_RAM,R_LAT,R_YM,R_K7} and ROM FSM state typedef.
//  One sub-module z80_rom_fetch (ROM FSM + wait generation). Decode, mux and latch stay in the top level.
// TESTING
//  MEMRD 16'h1234, rom_ack 5 cycles later with 8'hA5 -> rom_addr=15'h1234, nwait low exactly until 1 cycle after ack, z_din=A5.
//  MEMWR 16'h8010 data 3C -> ram_cs=ram_we=1 one cycle after strobe; MEMRD 8010 with ram_q=3C -> z_din=3C, nwait stays 1.
//  lat_wr data 42 -> z_nint=0 next cycle; MEMRD A000 -> z_din=42, z_nint returns 1.
//  lat_wr coincident with A000 read strobe -> z_nint stays 0, z_din = previous latch value.
//  Refresh cycle (nmreq=0, nrfsh=0, addr 0005) -> no rom_req, no cs. MEMRD 16'hE000 -> z_din=FF.
//  reset during REQ, then rom_ack -> rom_req=0, z_nwait=1, FSM in IDLE, ack ignored.

Source files
------------

// File: rtl/snd_bus_pkg.sv
// rtl/snd_bus_pkg.sv - shared types and address decode for the sound Z80 bus controller
package snd_bus_pkg;

  typedef enum logic [2:0] {
    R_NONE,
    R_ROM,
    R_RAM,
    R_LAT,
    R_YM,
    R_K7
  } region_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_HOLD
  } fetch_state_t;

  localparam logic [15:0] DEF_ROM_TOP  = 16'h7FFF;
  localparam logic [15:0] DEF_RAM_BASE = 16'h8000;
  localparam logic [15:0] DEF_LAT_BASE = 16'hA000;
  localparam logic [15:0] DEF_YM_BASE  = 16'hC000;
  localparam logic [15:0] DEF_K7_BASE  = 16'hB000;

  // Map an address to the device window it falls in; ROM takes priority.
  function automatic region_t decode_region(
    input logic [15:0] a,
    input logic [15:0] rom_top,
    input logic [15:0] ram_base,
    input logic [15:0] lat_base,
    input logic [15:0] ym_base,
    input logic [15:0] k7_base
  );
    region_t r;
    r = R_NONE;
    if (a <= rom_top)                      r = R_ROM;
    else if (a == lat_base)                r = R_LAT;
    else if (a[15:1] == ym_base[15:1])     r = R_YM;
    else if (a[15:4] == k7_base[15:4])     r = R_K7;
    else if (a[15:11] == ram_base[15:11])  r = R_RAM;
    return r;
  endfunction

endpackage

// File: rtl/z80_rom_fetch.sv
// rtl/z80_rom_fetch.sv - ROM fetch sequencer with WAIT_n generation
module z80_rom_fetch
  import snd_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] addr,
  input  logic        z_nrd,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  output logic        z_nwait,
  output logic [7:0]  rom_q
);

  fetch_state_t state, state_nx;
  logic         req_nx;
  logic         nwait_nx;
  logic [14:0]  addr_nx;
  logic [7:0]   q_nx;

  // State and registered outputs; reset drops any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= F_IDLE;
      rom_req  <= 1'b0;
      z_nwait  <= 1'b1;
      rom_addr <= '0;
      rom_q    <= 8'hFF;
    end else begin
      state    <= state_nx;
      rom_req  <= req_nx;
      z_nwait  <= nwait_nx;
      rom_addr <= addr_nx;
      rom_q    <= q_nx;
    end
  end

  // Next state: request on a new ROM read, release WAIT_n on ack, rearm when RD_n rises.
  always_comb begin
    state_nx = state;
    req_nx   = rom_req;
    nwait_nx = z_nwait;
    addr_nx  = rom_addr;
    q_nx     = rom_q;
    case (state)
      F_IDLE: begin
        if (start) begin
          addr_nx  = addr;
          req_nx   = 1'b1;
          nwait_nx = 1'b0;
          state_nx = F_REQ;
        end
      end
      F_REQ: begin
        if (rom_ack) begin
          q_nx     = rom_data;
          req_nx   = 1'b0;
          nwait_nx = 1'b1;
          state_nx = F_HOLD;
        end
      end
      F_HOLD: begin
        if (z_nrd) state_nx = F_IDLE;
      end
      default: begin
        state_nx = F_IDLE;
        req_nx   = 1'b0;
        nwait_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/z80_snd_bus_ctrl.sv
// rtl/z80_snd_bus_ctrl.sv - sound Z80 decode, read mux, sound latch and INT_n
module z80_snd_bus_ctrl
  import snd_bus_pkg::*;
#(
  parameter logic [15:0] ROM_TOP  = DEF_ROM_TOP,
  parameter logic [15:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [15:0] LAT_BASE = DEF_LAT_BASE,
  parameter logic [15:0] YM_BASE  = DEF_YM_BASE,
  parameter logic [15:0] K7_BASE  = DEF_K7_BASE
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] z_addr,
  input  logic [7:0]  z_dout,
  input  logic        z_nmreq,
  input  logic        z_niorq,
  input  logic        z_nrd,
  input  logic        z_nwr,
  input  logic        z_nrfsh,
  output logic [7:0]  z_din,
  output logic        z_nwait,
  output logic        z_nint,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic        ram_cs,
  output logic        ram_we,
  input  logic [7:0]  ram_q,
  output logic        ym_cs,
  output logic        ym_we,
  input  logic [7:0]  ym_q,
  output logic        k7_cs,
  output logic        k7_we,
  input  logic [7:0]  k7_q,
  input  logic        lat_wr,
  input  logic [7:0]  lat_data
);

  logic       memrd, memwr, memrd_q, memrd_rise, io_rd, access;
  logic       rom_start, lat_clear;
  logic [7:0] latch, rom_q;
  logic       irq_pend;
  region_t    region;
  logic       unused_dout;

  // Peripherals take write data straight from the CPU bus.
  assign unused_dout = ^z_dout;

  assign memrd      = ~z_nmreq & z_nrfsh & ~z_nrd;
  assign memwr      = ~z_nmreq & z_nrfsh & ~z_nwr;
  assign io_rd      = ~z_niorq & ~z_nrd;
  assign access     = memrd | memwr;
  assign memrd_rise = memrd & ~memrd_q;
  assign region     = decode_region(z_addr, ROM_TOP, RAM_BASE, LAT_BASE, YM_BASE, K7_BASE);
  assign rom_start  = memrd_rise && (region == R_ROM);
  assign lat_clear  = memrd_rise && (region == R_LAT);

  // Previous read strobe, used to act once per read cycle.
  always_ff @(posedge clk) begin
    if (reset) memrd_q <= 1'b0;
    else       memrd_q <= memrd;
  end

  // Registered chip selects; ROM and latch windows have no select outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_cs <= 1'b0; ram_we <= 1'b0;
      ym_cs  <= 1'b0; ym_we  <= 1'b0;
      k7_cs  <= 1'b0; k7_we  <= 1'b0;
    end else begin
      ram_cs <= access && (region == R_RAM);
      ram_we <= memwr  && (region == R_RAM);
      ym_cs  <= access && (region == R_YM);
      ym_we  <= memwr  && (region == R_YM);
      k7_cs  <= access && (region == R_K7);
      k7_we  <= memwr  && (region == R_K7);
    end
  end

  // Sound latch and pending interrupt; a 68k write beats a same-cycle clearing read.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch    <= 8'h00;
      irq_pend <= 1'b0;
      z_nint   <= 1'b1;
    end else if (lat_wr) begin
      latch    <= lat_data;
      irq_pend <= 1'b1;
      z_nint   <= 1'b0;
    end else if (lat_clear) begin
      irq_pend <= 1'b0;
      z_nint   <= 1'b1;
    end
  end

  // Read data mux; latch is sampled only at the start of its read so a racing write is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_din <= 8'hFF;
    end else if (memrd) begin
      case (region)
        R_ROM:   z_din <= rom_q;
        R_RAM:   z_din <= ram_q;
        R_YM:    z_din <= ym_q;
        R_K7:    z_din <= k7_q;
        R_LAT:   if (memrd_rise) z_din <= latch;
        default: z_din <= 8'hFF;
      endcase
    end else if (io_rd) begin
      z_din <= 8'hFF;
    end
  end

  z80_rom_fetch u_fetch (
    .clk      (clk),
    .reset    (reset),
    .start    (rom_start),
    .addr     (z_addr[14:0]),
    .z_nrd    (z_nrd),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .z_nwait  (z_nwait),
    .rom_q    (rom_q)
  );

endmodule

// File: tb/tb_z80_snd_bus_ctrl.sv
// tb/tb_z80_snd_bus_ctrl.sv - self-checking bench for z80_snd_bus_ctrl
module tb_z80_snd_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] z_addr;
  logic [7:0]  z_dout;
  logic        z_nmreq, z_niorq, z_nrd, z_nwr, z_nrfsh;
  logic [7:0]  z_din;
  logic        z_nwait, z_nint;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic        ram_cs, ram_we, ym_cs, ym_we, k7_cs, k7_we;
  logic [7:0]  ram_q, ym_q, k7_q;
  logic        lat_wr;
  logic [7:0]  lat_data;
  logic [5:0]  cs_obs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_latch;
  logic       m_pend;

  always #5 clk = ~clk;

  assign cs_obs = {ram_cs, ram_we, ym_cs, ym_we, k7_cs, k7_we};

  z80_snd_bus_ctrl dut (
    .clk(clk), .reset(reset), .z_addr(z_addr), .z_dout(z_dout),
    .z_nmreq(z_nmreq), .z_niorq(z_niorq), .z_nrd(z_nrd), .z_nwr(z_nwr), .z_nrfsh(z_nrfsh),
    .z_din(z_din), .z_nwait(z_nwait), .z_nint(z_nint),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_q(ram_q),
    .ym_cs(ym_cs), .ym_we(ym_we), .ym_q(ym_q),
    .k7_cs(k7_cs), .k7_we(k7_we), .k7_q(k7_q),
    .lat_wr(lat_wr), .lat_data(lat_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory map: 0 none, 1 rom, 2 ram, 3 latch, 4 ym, 5 k7.
  function automatic int mregion(input logic [15:0] a);
    int v;
    v = int'(a);
    if (v <= 'h7FFF) return 1;
    if (v == 'hA000) return 3;
    if (v / 2 == 'hC000 / 2) return 4;
    if (v / 16 == 'hB000 / 16) return 5;
    if (v >= 'h8000 && v < 'h8800) return 2;
    return 0;
  endfunction

  function automatic logic [5:0] exp_cs(input int r, input logic wr);
    logic [5:0] v;
    v = 6'b0;
    if (r == 2)      v = {1'b1, wr, 4'b0};
    else if (r == 4) v = {2'b0, 1'b1, wr, 2'b0};
    else if (r == 5) v = {4'b0, 1'b1, wr};
    return v;
  endfunction

  task automatic idle_bus();
    z_nmreq = 1'b1; z_niorq = 1'b1; z_nrd = 1'b1; z_nwr = 1'b1; z_nrfsh = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, input int ack_dly, input logic [7:0] rdat,
                          input logic with_lw, input logic [7:0] new_lat);
    int r;
    int low;
    logic [7:0] exp_din;
    r   = mregion(a);
    low = 0;
    case (r)
      1: exp_din = rdat;
      2: exp_din = ram_q;
      3: exp_din = m_latch;
      4: exp_din = ym_q;
      5: exp_din = k7_q;
      default: exp_din = 8'hFF;
    endcase
    if (with_lw) begin
      m_latch = new_lat;
      m_pend  = 1'b1;
    end else if (r == 3) begin
      m_pend = 1'b0;
    end
    @(negedge clk);
    z_addr = a; z_nmreq = 1'b0; z_nrd = 1'b0;
    if (with_lw) begin lat_wr = 1'b1; lat_data = new_lat; end
    @(negedge clk);
    lat_wr = 1'b0;
    check("rd_cs", cs_obs, exp_cs(r, 1'b0));
    check("rd_nint", z_nint, !m_pend);
    if (r == 1) begin
      check("rom_addr", rom_addr, a[14:0]);
      for (int i = 0; i < ack_dly; i++) begin
        if (z_nwait === 1'b0 && rom_req === 1'b1) low++;
        if (i == ack_dly - 1) begin rom_ack = 1'b1; rom_data = rdat; end
        @(negedge clk);
      end
      rom_ack = 1'b0;
      check("rom_stall", low, ack_dly);
      check("rom_nwait_rel", z_nwait, 1'b1);
      check("rom_req_drop", rom_req, 1'b0);
      @(negedge clk);
    end else begin
      check("rd_nwait", z_nwait, 1'b1);
      check("rd_noreq", rom_req, 1'b0);
      @(negedge clk);
    end
    check("rd_din", z_din, exp_din);
    idle_bus();
    @(negedge clk);
    check("rd_cs_drop", cs_obs, 6'b0);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    int r;
    r = mregion(a);
    @(negedge clk);
    z_addr = a; z_dout = d; z_nmreq = 1'b0; z_nwr = 1'b0;
    @(negedge clk);
    check("wr_cs", cs_obs, exp_cs(r, 1'b1));
    check("wr_noreq", rom_req, 1'b0);
    idle_bus();
    @(negedge clk);
    check("wr_cs_drop", cs_obs, 6'b0);
  endtask

  task automatic latch_write(input logic [7:0] d);
    @(negedge clk);
    lat_wr = 1'b1; lat_data = d;
    @(negedge clk);
    lat_wr = 1'b0;
    m_latch = d; m_pend = 1'b1;
    check("lat_nint", z_nint, 1'b0);
  endtask

  task automatic odd_cycle(input logic io, input logic [15:0] a);
    @(negedge clk);
    z_addr = a; z_nrd = 1'b0;
    if (io) z_niorq = 1'b0;
    else begin z_nmreq = 1'b0; z_nrfsh = 1'b0; end
    @(negedge clk);
    check("odd_cs", cs_obs, 6'b0);
    check("odd_noreq", rom_req, 1'b0);
    check("odd_nwait", z_nwait, 1'b1);
    @(negedge clk);
    if (io) check("io_din", z_din, 8'hFF);
    check("odd_noreq2", rom_req, 1'b0);
    idle_bus();
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr(input int r);
    logic [15:0] a;
    case (r)
      1: a = 16'($urandom) & 16'h7FFF;
      2: a = 16'h8000 + 16'($urandom_range(0, 2047));
      3: a = 16'hA000;
      4: a = 16'hC000 + 16'($urandom_range(0, 1));
      5: a = 16'hB000 + 16'($urandom_range(0, 15));
      default: a = 16'hE000 + 16'($urandom_range(0, 4095));
    endcase
    return a;
  endfunction

  initial begin
    logic [15:0] bounds [6];
    idle_bus();
    z_addr = 16'h0; z_dout = 8'h0; rom_ack = 1'b0; rom_data = 8'h0;
    ram_q = 8'h0; ym_q = 8'h0; k7_q = 8'h0; lat_wr = 1'b0; lat_data = 8'h0;
    m_latch = 8'h00; m_pend = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_nwait", z_nwait, 1'b1);
    check("rst_nint", z_nint, 1'b1);
    check("rst_req", rom_req, 1'b0);
    check("rst_addr", rom_addr, 15'h0);
    check("rst_cs", cs_obs, 6'b0);
    check("rst_din", z_din, 8'hFF);
    reset = 1'b0;

    bus_read(16'h1234, 5, 8'hA5, 1'b0, 8'h00);
    ram_q = 8'h3C;
    bus_write(16'h8010, 8'h3C);
    bus_read(16'h8010, 1, 8'h00, 1'b0, 8'h00);
    latch_write(8'h42);
    bus_read(16'hA000, 1, 8'h00, 1'b0, 8'h00);
    latch_write(8'h55);
    bus_read(16'hA000, 1, 8'h00, 1'b1, 8'h99);
    check("race_nint_held", z_nint, 1'b0);
    bus_read(16'hA000, 1, 8'h00, 1'b0, 8'h00);
    odd_cycle(1'b0, 16'h0005);
    bus_read(16'hE000, 1, 8'h00, 1'b0, 8'h00);
    bus_write(16'h0040, 8'h11);
    bus_read(16'h2000, 2, 8'h5A, 1'b0, 8'h00);
    odd_cycle(1'b1, 16'h1234);

    ym_q = 8'h81; k7_q = 8'h7E; ram_q = 8'hC3;
    bounds[0] = 16'h7FFF; bounds[1] = 16'h87FF; bounds[2] = 16'h8800;
    bounds[3] = 16'hC001; bounds[4] = 16'hC002; bounds[5] = 16'hB00F;
    foreach (bounds[i]) bus_read(bounds[i], 1, 8'h3A, 1'b0, 8'h00);

    // Reset while a fetch is outstanding; the ack that follows must be ignored.
    @(negedge clk);
    z_addr = 16'h0100; z_nmreq = 1'b0; z_nrd = 1'b0;
    @(negedge clk);
    check("mid_req", rom_req, 1'b1);
    reset = 1'b1; idle_bus();
    @(negedge clk);
    reset = 1'b0; m_latch = 8'h00; m_pend = 1'b0;
    check("mid_rst_req", rom_req, 1'b0);
    check("mid_rst_nwait", z_nwait, 1'b1);
    check("mid_rst_nint", z_nint, 1'b1);
    rom_ack = 1'b1; rom_data = 8'h77;
    @(negedge clk);
    rom_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", rom_req, 1'b0);
    check("late_ack_nwait", z_nwait, 1'b1);
    check("late_ack_din", z_din, 8'hFF);
    bus_read(16'h0100, 3, 8'h66, 1'b0, 8'h00);
    bus_read(16'hA000, 1, 8'h00, 1'b0, 8'h00);

    for (int n = 0; n < 60; n++) begin
      int op;
      int r;
      op = $urandom_range(0, 3);
      r  = $urandom_range(0, 5);
      ram_q = 8'($urandom); ym_q = 8'($urandom); k7_q = 8'($urandom);
      case (op)
        0: latch_write(8'($urandom));
        1: bus_read(rand_addr(r), $urandom_range(1, 6), 8'($urandom),
                    ($urandom_range(0, 3) == 0), 8'($urandom));
        2: bus_write(rand_addr(r), 8'($urandom));
        default: odd_cycle(1'($urandom), rand_addr(r));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
